// File: rtl/baser_rx_block_lock_ctrl_if.sv
// Sync-header bus between the gearbox and the block lock controller.
// Carries the qualified header in and the lock/slip status out.
interface baser_rx_block_lock_ctrl_if #(
  parameter int HDR_WIDTH      = 2,
  parameter int SLIP_CNT_WIDTH = 8
);
  logic [HDR_WIDTH-1:0]      encoded_rx_hdr;
  logic                      encoded_rx_hdr_valid;
  logic                      serdes_rx_bitslip;
  logic                      rx_block_lock;
  logic                      rx_high_ber;
  logic                      rx_status;
  logic [SLIP_CNT_WIDTH-1:0] rx_slip_count;

  modport master (
    output encoded_rx_hdr,
    output encoded_rx_hdr_valid,
    input  serdes_rx_bitslip,
    input  rx_block_lock,
    input  rx_high_ber,
    input  rx_status,
    input  rx_slip_count
  );

  modport slave (
    input  encoded_rx_hdr,
    input  encoded_rx_hdr_valid,
    output serdes_rx_bitslip,
    output rx_block_lock,
    output rx_high_ber,
    output rx_status,
    output rx_slip_count
  );
endinterface

// File: rtl/baser_rx_block_lock_ctrl.sv
// 64b/66b block lock: bitslip search, windowed unlock and BER monitor.
// All outputs registered, one cycle after the deciding header.
module baser_rx_block_lock_ctrl #(
  parameter int HDR_WIDTH      = 2,
  parameter int LOCK_GOOD_CNT  = 64,
  parameter int LOCK_WINDOW    = 1024,
  parameter int UNLOCK_BAD_CNT = 16,
  parameter int SLIP_HOLDOFF   = 32,
  parameter int BER_WINDOW     = 19531,
  parameter int BER_THRESH     = 97,
  parameter int SLIP_CNT_WIDTH = 8
) (
  input logic clk,
  input logic rst,
  baser_rx_block_lock_ctrl_if.slave rx_if
);

  localparam int GW = $clog2(LOCK_GOOD_CNT + 1);
  localparam int WW = $clog2(LOCK_WINDOW + 1);
  localparam int BW = $clog2(UNLOCK_BAD_CNT + 1);
  localparam int HW = $clog2(SLIP_HOLDOFF + 1);
  localparam int RW = $clog2(BER_WINDOW + 1);
  localparam int TW = $clog2(BER_THRESH + 1);
  localparam int SW = SLIP_CNT_WIDTH;

  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_GOOD_CNT - 1);
  localparam logic [WW-1:0] WIN_LAST  = WW'(LOCK_WINDOW - 1);
  localparam logic [BW-1:0] BAD_LAST  = BW'(UNLOCK_BAD_CNT - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(SLIP_HOLDOFF - 1);
  localparam logic [RW-1:0] BER_LAST  = RW'(BER_WINDOW - 1);
  localparam logic [TW-1:0] BER_TH    = TW'(BER_THRESH);

  localparam logic [HDR_WIDTH-1:0] SH_DATA = HDR_WIDTH'(2'b01);
  localparam logic [HDR_WIDTH-1:0] SH_CTRL = HDR_WIDTH'(2'b10);

  typedef enum logic [1:0] {
    UNLOCKED,
    SLIP_WAIT,
    LOCKED
  } state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] good_q, good_d;
  logic [WW-1:0] win_q, win_d;
  logic [BW-1:0] bad_q, bad_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [RW-1:0] bcnt_q, bcnt_d;
  logic [TW-1:0] bbad_q, bbad_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic          slip_q, slip_d;
  logic          lock_q, lock_d;
  logic          hber_q, hber_d;
  logic          stat_q, stat_d;

  logic          qual;
  logic          hdr_ok;
  logic [TW-1:0] bbad_inc;
  logic [SW-1:0] scnt_inc;

  assign qual   = rx_if.encoded_rx_hdr_valid;
  assign hdr_ok = (rx_if.encoded_rx_hdr == SH_DATA) ||
                  (rx_if.encoded_rx_hdr == SH_CTRL);

  assign bbad_inc = (!hdr_ok && bbad_q != BER_TH) ?
                    bbad_q + TW'(1) : bbad_q;
  assign scnt_inc = (&scnt_q) ? scnt_q : scnt_q + SW'(1);

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    win_d   = win_q;
    bad_d   = bad_q;
    hold_d  = hold_q;
    bcnt_d  = bcnt_q;
    bbad_d  = bbad_q;
    scnt_d  = scnt_q;
    slip_d  = 1'b0;
    lock_d  = lock_q;
    hber_d  = hber_q;
    unique case (state_q)
      UNLOCKED: begin
        if (qual && hdr_ok) begin
          if (good_q == GOOD_LAST) begin
            state_d = LOCKED;
            lock_d  = 1'b1;
            good_d  = '0;
            win_d   = '0;
            bad_d   = '0;
            bcnt_d  = '0;
            bbad_d  = '0;
            hber_d  = 1'b0;
          end else begin
            good_d = good_q + GW'(1);
          end
        end else if (qual) begin
          state_d = SLIP_WAIT;
          slip_d  = 1'b1;
          scnt_d  = scnt_inc;
          good_d  = '0;
          hold_d  = '0;
        end
      end
      SLIP_WAIT: begin
        // Gearbox output is unsettled after a slip; count raw clocks.
        if (hold_q == HOLD_LAST) begin
          state_d = UNLOCKED;
          hold_d  = '0;
          good_d  = '0;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      LOCKED: begin
        if (qual && !hdr_ok && bad_q == BAD_LAST) begin
          state_d = SLIP_WAIT;
          lock_d  = 1'b0;
          hber_d  = 1'b0;
          slip_d  = 1'b1;
          scnt_d  = scnt_inc;
          hold_d  = '0;
          win_d   = '0;
          bad_d   = '0;
          bcnt_d  = '0;
          bbad_d  = '0;
        end else if (qual) begin
          if (win_q == WIN_LAST) begin
            win_d = '0;
            bad_d = '0;
          end else begin
            win_d = win_q + WW'(1);
            bad_d = hdr_ok ? bad_q : bad_q + BW'(1);
          end
          if (bcnt_q == BER_LAST) begin
            hber_d = (bbad_inc >= BER_TH);
            bcnt_d = '0;
            bbad_d = '0;
          end else begin
            bcnt_d = bcnt_q + RW'(1);
            bbad_d = bbad_inc;
          end
        end
      end
      default: begin
        state_d = UNLOCKED;
        lock_d  = 1'b0;
        hber_d  = 1'b0;
      end
    endcase
    stat_d = lock_d & ~hber_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= UNLOCKED;
      good_q  <= '0;
      win_q   <= '0;
      bad_q   <= '0;
      hold_q  <= '0;
      bcnt_q  <= '0;
      bbad_q  <= '0;
      scnt_q  <= '0;
      slip_q  <= 1'b0;
      lock_q  <= 1'b0;
      hber_q  <= 1'b0;
      stat_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      win_q   <= win_d;
      bad_q   <= bad_d;
      hold_q  <= hold_d;
      bcnt_q  <= bcnt_d;
      bbad_q  <= bbad_d;
      scnt_q  <= scnt_d;
      slip_q  <= slip_d;
      lock_q  <= lock_d;
      hber_q  <= hber_d;
      stat_q  <= stat_d;
    end
  end

  assign rx_if.serdes_rx_bitslip = slip_q;
  assign rx_if.rx_block_lock     = lock_q;
  assign rx_if.rx_high_ber       = hber_q;
  assign rx_if.rx_status         = stat_q;
  assign rx_if.rx_slip_count     = scnt_q;

endmodule

// File: tb/tb_baser_rx_block_lock_ctrl.sv
// Randomized bench for baser_rx_block_lock_ctrl against a header-level model.
// BER window shortened to 200 headers / threshold 10.
module tb_baser_rx_block_lock_ctrl;

  localparam int LGC  = 64;
  localparam int LW   = 1024;
  localparam int UBC  = 16;
  localparam int HOLD = 32;
  localparam int BWIN = 200;
  localparam int BTH  = 10;
  localparam int SMAX = 255;

  logic clk;
  logic rst;

  baser_rx_block_lock_ctrl_if #(.HDR_WIDTH(2), .SLIP_CNT_WIDTH(8)) bus ();

  baser_rx_block_lock_ctrl #(
    .HDR_WIDTH(2),
    .LOCK_GOOD_CNT(LGC),
    .LOCK_WINDOW(LW),
    .UNLOCK_BAD_CNT(UBC),
    .SLIP_HOLDOFF(HOLD),
    .BER_WINDOW(BWIN),
    .BER_THRESH(BTH),
    .SLIP_CNT_WIDTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_if(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 0;

  // model: 0 searching, 1 waiting after slip, 2 locked
  int m_mode, m_run, m_wait_left, m_win, m_bad, m_bcnt, m_bbad;
  int e_slip, e_lock, e_hber, e_stat, e_cnt;
  int n_slips;

  task automatic cmp(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_run = 0; m_wait_left = 0;
    m_win = 0; m_bad = 0; m_bcnt = 0; m_bbad = 0;
    e_slip = 0; e_lock = 0; e_hber = 0; e_stat = 0; e_cnt = 0;
  endtask

  task automatic model_slip();
    e_slip = 1;
    n_slips++;
    e_cnt = (e_cnt < SMAX) ? e_cnt + 1 : SMAX;
    m_mode = 1;
    m_wait_left = HOLD;
    m_run = 0;
  endtask

  task automatic model_step(int h, int v);
    bit ok;
    ok = (h == 1) || (h == 2);
    e_slip = 0;
    if (m_mode == 1) begin
      m_wait_left--;
      if (m_wait_left == 0) begin
        m_mode = 0;
        m_run = 0;
      end
    end else if (m_mode == 0 && v) begin
      if (!ok) model_slip();
      else if (++m_run == LGC) begin
        m_mode = 2; e_lock = 1; e_hber = 0;
        m_win = 0; m_bad = 0; m_bcnt = 0; m_bbad = 0;
      end
    end else if (m_mode == 2 && v) begin
      m_win++;
      if (!ok) m_bad++;
      if (m_bad == UBC) begin
        e_lock = 0; e_hber = 0;
        m_win = 0; m_bad = 0; m_bcnt = 0; m_bbad = 0;
        model_slip();
      end else begin
        if (m_win == LW) begin
          m_win = 0; m_bad = 0;
        end
        m_bcnt++;
        if (!ok && m_bbad < BTH) m_bbad++;
        if (m_bcnt == BWIN) begin
          e_hber = (m_bbad >= BTH);
          m_bcnt = 0; m_bbad = 0;
        end
      end
    end
    e_stat = e_lock && !e_hber;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("bitslip", int'(bus.serdes_rx_bitslip), e_slip);
      cmp("block_lock", int'(bus.rx_block_lock), e_lock);
      cmp("high_ber", int'(bus.rx_high_ber), e_hber);
      cmp("status", int'(bus.rx_status), e_stat);
      cmp("slip_count", int'(bus.rx_slip_count), e_cnt);
    end
  end

  task automatic drive(int h, int v);
    bus.encoded_rx_hdr = 2'(h);
    bus.encoded_rx_hdr_valid = v[0];
    @(posedge clk);
    model_step(h, v);
    #1;
  endtask

  task automatic good_hdr();
    drive(int'($urandom_range(1, 2)), 1);
  endtask

  task automatic bad_hdr();
    drive(($urandom_range(0, 1) == 0) ? 0 : 3, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    bus.encoded_rx_hdr = 2'b00;
    bus.encoded_rx_hdr_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic lock_up();
    for (int i = 0; i < LGC; i++) good_hdr();
  endtask

  // n qualified headers, exactly k bad at random slots, random gaps
  task automatic send_mix(int n, int k, bit stop_at_last);
    int left;
    left = k;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 7) == 0) drive(1, 0);
      if (left > 0 && int'($urandom_range(0, n - i - 1)) < left) begin
        bad_hdr();
        left--;
        if (stop_at_last && left == 0) return;
      end else begin
        good_hdr();
      end
    end
  endtask

  initial begin
    n_slips = 0;
    rst = 1'b1;
    model_reset();
    bus.encoded_rx_hdr = 2'b00;
    bus.encoded_rx_hdr_valid = 1'b0;
    chk_en = 1;
    #2;
    cmp("rst_lock", int'(bus.rx_block_lock), 0);
    cmp("rst_count", int'(bus.rx_slip_count), 0);
    do_reset();

    // aligned stream
    for (int i = 0; i < LGC - 1; i++) drive(1, 1);
    cmp("t1_not_yet", int'(bus.rx_block_lock), 0);
    drive(1, 1);
    cmp("t1_lock", int'(bus.rx_block_lock), 1);
    cmp("t1_status", int'(bus.rx_status), 1);
    cmp("t1_count", int'(bus.rx_slip_count), 0);

    // misaligned start
    do_reset();
    drive(0, 1);
    cmp("t2_pulse", int'(bus.serdes_rx_bitslip), 1);
    drive(0, 1);
    cmp("t2_pulse_end", int'(bus.serdes_rx_bitslip), 0);
    drive(0, 1);
    for (int i = 3; i < 96; i++) drive(2, 1);
    cmp("t2_not_yet", int'(bus.rx_block_lock), 0);
    drive(2, 1);
    cmp("t2_lock", int'(bus.rx_block_lock), 1);
    cmp("t2_count", int'(bus.rx_slip_count), 1);

    // windowed errors while locked
    do_reset();
    lock_up();
    send_mix(LW, UBC - 1, 0);
    cmp("t3_hold_w1", int'(bus.rx_block_lock), 1);
    send_mix(LW, UBC - 1, 0);
    cmp("t3_hold_w2", int'(bus.rx_block_lock), 1);
    send_mix(LW, UBC, 1);
    cmp("t3_unlock", int'(bus.rx_block_lock), 0);
    cmp("t3_slip", int'(bus.serdes_rx_bitslip), 1);
    cmp("t3_count", int'(bus.rx_slip_count), 1);
    for (int i = 0; i < 40; i++) good_hdr();

    // valid gaps do not break the run
    do_reset();
    for (int i = 0; i < LGC; i++) begin
      repeat ($urandom_range(0, 3)) drive(0, 0);
      good_hdr();
      if (i == LGC - 2) cmp("t4_not_yet", int'(bus.rx_block_lock), 0);
    end
    cmp("t4_lock", int'(bus.rx_block_lock), 1);

    // high BER then recovery
    do_reset();
    lock_up();
    send_mix(BWIN, BTH, 0);
    cmp("t5_hber", int'(bus.rx_high_ber), 1);
    cmp("t5_status", int'(bus.rx_status), 0);
    cmp("t5_lock", int'(bus.rx_block_lock), 1);
    send_mix(BWIN, 0, 0);
    cmp("t5_hber_clr", int'(bus.rx_high_ber), 0);
    cmp("t5_status_ok", int'(bus.rx_status), 1);

    // random traffic at two error densities
    do_reset();
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 4) == 0) drive(int'($urandom_range(0, 3)), 0);
      else if ($urandom_range(0, (i < 3000) ? 199 : 59) == 0) bad_hdr();
      else good_hdr();
    end

    // slip counter saturation
    do_reset();
    n_slips = 0;
    for (int i = 0; i < 20000 && n_slips < 300; i++) drive(0, 1);
    cmp("t6_slips", n_slips, 300);
    cmp("t6_sat", int'(bus.rx_slip_count), SMAX);

    // async reset in the middle of the holdoff
    for (int i = 0; i < 5; i++) drive(3, 1);
    cmp("t6_in_wait", int'(bus.serdes_rx_bitslip), 0);
    #2 rst = 1'b1;
    model_reset();
    #1;
    cmp("t6_arst_count", int'(bus.rx_slip_count), 0);
    cmp("t6_arst_lock", int'(bus.rx_block_lock), 0);
    cmp("t6_arst_slip", int'(bus.serdes_rx_bitslip), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    lock_up();
    cmp("t6_relock", int'(bus.rx_block_lock), 1);
    cmp("t6_relock_cnt", int'(bus.rx_slip_count), 0);

    @(negedge clk);
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
